// File: rtl/async_fifo_gray.sv
// Gray-pointer FIFO with 2-flop pointer synchronizers, run from one clock.
// Keeps the dual-clock structure so flag latency matches the async variant.
package conversionFunctions;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction

endpackage

module async_fifo_gray
  import conversionFunctions::*;
#(
  parameter int DATA_LEN   = 16,
  parameter int FIFO_DEPTH = 512,
  parameter int PNTR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                wr_clk,
  input  logic                reset,
  input  logic                write_en,
  input  logic [DATA_LEN-1:0] data_in,
  input  logic                read_en,
  output logic [DATA_LEN-1:0] data_out,
  output logic                fifo_full,
  output logic                fifo_empty
);

  localparam int MSB = PNTR_WIDTH;

  typedef logic [PNTR_WIDTH:0] ptr_t;

  logic [DATA_LEN-1:0] mem [FIFO_DEPTH];

  ptr_t wr_bin, wr_gray, wr_bin_next, wr_gray_next;
  ptr_t rd_bin, rd_gray, rd_bin_next, rd_gray_next;
  ptr_t rq1_wr, rq2_wr, wq1_rd, wq2_rd;
  ptr_t full_cmp;
  logic wr_ok, rd_ok;

  assign wr_ok = write_en & ~fifo_full;
  assign rd_ok = read_en & ~fifo_empty;

  assign wr_bin_next  = wr_bin + ptr_t'(wr_ok);
  assign rd_bin_next  = rd_bin + ptr_t'(rd_ok);
  assign wr_gray_next = ptr_t'(bin2gray(32'(wr_bin_next)));
  assign rd_gray_next = ptr_t'(bin2gray(32'(rd_bin_next)));

  // Full when write is exactly one lap ahead: top two Gray bits inverted.
  assign full_cmp = {~rq2_wr[MSB -: 2], rq2_wr[MSB-2:0]};

  always_ff @(posedge wr_clk) begin
    if (wr_ok) mem[wr_bin[PNTR_WIDTH-1:0]] <= data_in;
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      wr_bin    <= '0;
      wr_gray   <= '0;
      rq1_wr    <= '0;
      rq2_wr    <= '0;
      fifo_full <= 1'b0;
    end else begin
      wr_bin    <= wr_bin_next;
      wr_gray   <= wr_gray_next;
      rq1_wr    <= rd_gray;
      rq2_wr    <= rq1_wr;
      fifo_full <= (wr_gray_next == full_cmp);
    end
  end

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      rd_bin     <= '0;
      rd_gray    <= '0;
      wq1_rd     <= '0;
      wq2_rd     <= '0;
      fifo_empty <= 1'b1;
      data_out   <= '0;
    end else begin
      rd_bin     <= rd_bin_next;
      rd_gray    <= rd_gray_next;
      wq1_rd     <= wr_gray;
      wq2_rd     <= wq1_rd;
      fifo_empty <= (rd_gray_next == wq2_rd);
      if (rd_ok) data_out <= mem[rd_bin[PNTR_WIDTH-1:0]];
    end
  end

endmodule

// File: tb/tb_async_fifo_gray.sv
// Scoreboard bench for async_fifo_gray: fill/overflow, underflow,
// wrap-around, steady half-full streaming and asynchronous reset.
module tb_async_fifo_gray;
  import conversionFunctions::*;

  logic        wr_clk = 1'b0;
  logic        reset;
  logic        write_en;
  logic [15:0] data_in;
  logic        read_en;
  logic [15:0] data_out;
  logic        fifo_full;
  logic        fifo_empty;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb [$];

  async_fifo_gray #(
    .DATA_LEN  (16),
    .FIFO_DEPTH(512)
  ) dut (
    .wr_clk    (wr_clk),
    .reset     (reset),
    .write_en  (write_en),
    .data_in   (data_in),
    .read_en   (read_en),
    .data_out  (data_out),
    .fifo_full (fifo_full),
    .fifo_empty(fifo_empty)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic w, input logic r,
                      input logic [15:0] d);
    write_en = w;
    read_en  = r;
    data_in  = d;
    @(negedge wr_clk);
  endtask

  task automatic push_wr(input logic [15:0] d, input logic r);
    sb.push_back(d);
    step(1'b1, r, d);
  endtask

  task automatic pop_chk(input string tag);
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 1, 0);
    else chk(tag, data_out, sb.pop_front());
  endtask

  task automatic do_reset();
    write_en = 0;
    read_en  = 0;
    data_in  = '0;
    reset    = 1'b1;
    repeat (2) @(negedge wr_clk);
    reset = 1'b0;
    sb.delete();
    @(negedge wr_clk);
  endtask

  task automatic wait_not_empty();
    int n = 0;
    while (fifo_empty && n < 8) begin
      step(1'b0, 1'b0, '0);
      n++;
    end
    chk("empty_drop_timeout", fifo_empty, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int vals [10] = '{0, 10, 51, 511, 1, 45, 100, 101, 250, 41};
    reset    = 1'b1;
    write_en = 0;
    read_en  = 0;
    data_in  = '0;

    foreach (vals[i])
      chk("gray_rt", gray2bin(bin2gray(vals[i])), vals[i]);
    chk("gray_10", bin2gray(32'd10), 32'd15);

    do_reset();
    chk("rst_dout", data_out, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);

    for (int i = 0; i < 512; i++) begin
      push_wr(16'(i), 1'b0);
      chk("fill_full", fifo_full, (i == 511));
    end
    step(1'b1, 1'b0, 16'hDEAD);
    chk("ovf_full", fifo_full, 1);
    for (int k = 0; k < 512; k++) begin
      step(1'b0, 1'b1, '0);
      pop_chk("fill_rd");
      chk("fill_empty", fifo_empty, (k == 511));
    end
    step(1'b0, 1'b0, '0);
    chk("fill_sb_left", sb.size(), 0);

    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, '0);
      chk("udf_dout", data_out, 0);
      chk("udf_empty", fifo_empty, 1);
    end
    push_wr(16'h1234, 1'b0);
    wait_not_empty();
    step(1'b0, 1'b1, '0);
    pop_chk("udf_rd");
    chk("udf_empty_end", fifo_empty, 1);

    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 300; i++) begin
        push_wr(16'(p * 300 + i), 1'b0);
        chk("wrap_full", fifo_full, 0);
        if (i >= 3) chk("wrap_empty_w", fifo_empty, 0);
      end
      for (int k = 0; k < 300; k++) begin
        step(1'b0, 1'b1, '0);
        pop_chk("wrap_rd");
        chk("wrap_empty_r", fifo_empty, (k == 299));
      end
    end

    do_reset();
    for (int i = 0; i < 256; i++) push_wr(16'(i), 1'b0);
    wait_not_empty();
    for (int i = 0; i < 1000; i++) begin
      push_wr(16'(256 + i), 1'b1);
      pop_chk("sim_rd");
      chk("sim_full", fifo_full, 0);
      chk("sim_empty", fifo_empty, 0);
    end
    chk("sim_occ", sb.size(), 256);
    for (int k = 0; k < 256; k++) begin
      step(1'b0, 1'b1, '0);
      pop_chk("sim_drain");
      chk("sim_drain_empty", fifo_empty, (k == 255));
    end

    do_reset();
    for (int i = 0; i < 100; i++) push_wr(16'(16'h4000 + i), 1'b0);
    write_en = 0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_empty", fifo_empty, 1);
    chk("mid_rst_full", fifo_full, 0);
    chk("mid_rst_dout", data_out, 0);
    sb.delete();
    #1 reset = 1'b0;
    @(negedge wr_clk);
    push_wr(16'hBEEF, 1'b0);
    wait_not_empty();
    step(1'b0, 1'b1, '0);
    pop_chk("mid_rst_rd");
    chk("mid_rst_empty_end", fifo_empty, 1);
    step(1'b0, 1'b1, '0);
    chk("mid_rst_hold", data_out, 16'hBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
